flag_reg_unit: RTL and testbench

Flag register and condition evaluator that sits on the result side of the ALU. It latches the ALU's N/Z/C/V flags under a per-flag write mask and keeps a LIFO shadow stack so interrupt entry/return can save and restore flags. It also evaluates the 4-bit branch condition field against the registered flags for the sequencer.

---
 rtl/flag_reg_unit_pkg.sv | 39 +++
 rtl/flag_reg_unit_cond_eval.sv | 50 +++++
 rtl/flag_reg_unit.sv | 120 ++++++++++++
 tb/tb_flag_reg_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_reg_unit_pkg.sv
// ============================================================================
// flag_reg_unit_pkg : flag layout and branch condition encodings shared by the
//                     flag register, the decoder and the ALU.
// Revision: 1.0
// ============================================================================
`default_nettype none

package flag_reg_unit_pkg;

    localparam int FR_FLAG_W = 4;
    localparam int COND_W    = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [COND_W-1:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_CS = 4'd3,
        COND_CC = 4'd4,
        COND_MI = 4'd5,
        COND_PL = 4'd6,
        COND_VS = 4'd7,
        COND_VC = 4'd8,
        COND_HI = 4'd9,
        COND_LS = 4'd10,
        COND_GE = 4'd11,
        COND_LT = 4'd12,
        COND_GT = 4'd13,
        COND_LE = 4'd14,
        COND_NV = 4'd15
    } cond_e;

endpackage

`default_nettype wire

// File: rtl/flag_reg_unit_cond_eval.sv
// ============================================================================
// cond_eval : combinational branch condition decode against a flag vector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cond_eval
    import flag_reg_unit_pkg::*;
(
    input  logic [FR_FLAG_W-1:0] flags,
    input  logic [COND_W-1:0]    cond,
    output logic                 cond_true
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = flags[FLAG_N];
    assign z_flag = flags[FLAG_Z];
    assign c_flag = flags[FLAG_C];
    assign v_flag = flags[FLAG_V];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = z_flag;
            COND_NE: cond_true = !z_flag;
            COND_CS: cond_true = c_flag;
            COND_CC: cond_true = !c_flag;
            COND_MI: cond_true = n_flag;
            COND_PL: cond_true = !n_flag;
            COND_VS: cond_true = v_flag;
            COND_VC: cond_true = !v_flag;
            COND_HI: cond_true = c_flag && !z_flag;
            COND_LS: cond_true = !c_flag || z_flag;
            COND_GE: cond_true = (n_flag == v_flag);
            COND_LT: cond_true = (n_flag != v_flag);
            COND_GT: cond_true = !z_flag && (n_flag == v_flag);
            COND_LE: cond_true = z_flag || (n_flag != v_flag);
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/flag_reg_unit.sv
// ============================================================================
// flag_reg_unit : masked N/Z/C/V flag register with a LIFO shadow stack for
//                 interrupt save/restore and a branch condition evaluator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module flag_reg_unit
    import flag_reg_unit_pkg::*;
#(
    parameter int FR_FLAG_W = 4,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FR_FLAG_W-1:0]         alu_flags,
    input  logic                         flag_we,
    input  logic [FR_FLAG_W-1:0]         flag_mask,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         err_clr,
    input  logic [COND_W-1:0]            cond,
    output logic [FR_FLAG_W-1:0]         flags,
    output logic                         cond_true,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         stack_err
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FR_FLAG_W-1:0] flags_q, flags_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 err_q, err_d;
    logic [FR_FLAG_W-1:0] stack_q [DEPTH];

    logic                 full_w;
    logic                 empty_w;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 err_set;
    logic [DEPTH_W-1:0]   rd_cnt;
    logic [PTR_W-1:0]     wr_idx;
    logic [PTR_W-1:0]     rd_idx;
    logic [FR_FLAG_W-1:0] masked_flags;

    assign full_w  = (depth_q == DEPTH_W'(DEPTH));
    assign empty_w = (depth_q == '0);

    // A simultaneous push/pop is rejected outright; only a lone legal request moves the stack.
    assign push_ok = push && !pop && !full_w;
    assign pop_ok  = pop && !push && !empty_w;
    assign err_set = (push && pop) || (push && full_w) || (pop && empty_w);

    assign rd_cnt = depth_q - DEPTH_W'(1);
    assign wr_idx = depth_q[PTR_W-1:0];
    assign rd_idx = rd_cnt[PTR_W-1:0];

    assign masked_flags = (flags_q & ~flag_mask) | (alu_flags & flag_mask);

    always_comb begin
        flags_d = flags_q;
        depth_d = depth_q;
        err_d   = err_q;

        if (pop_ok) begin
            flags_d = stack_q[rd_idx];
        end else if (flag_we) begin
            flags_d = masked_flags;
        end

        if (push_ok) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop_ok) begin
            depth_d = rd_cnt;
        end

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Saved entries hold the pre-update flags; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_q[wr_idx] <= flags_q;
        end
    end

    cond_eval u_cond_eval (
        .flags     (flags_q),
        .cond      (cond),
        .cond_true (cond_true)
    );

    assign flags       = flags_q;
    assign depth       = depth_q;
    assign stack_full  = full_w;
    assign stack_empty = empty_w;
    assign stack_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_flag_reg_unit.sv
// ============================================================================
// tb_flag_reg_unit : scoreboard bench for flag_reg_unit with a queue-based
//                    reference model and randomized traffic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_flag_reg_unit;

    localparam int DEPTH   = 4;
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic               clk;
    logic               rst;
    logic [3:0]         alu_flags;
    logic               flag_we;
    logic [3:0]         flag_mask;
    logic               push;
    logic               pop;
    logic               err_clr;
    logic [3:0]         cond;
    logic [3:0]         flags;
    logic               cond_true;
    logic [DEPTH_W-1:0] depth;
    logic               stack_full;
    logic               stack_empty;
    logic               stack_err;

    flag_reg_unit #(
        .FR_FLAG_W (4),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_flags   (alu_flags),
        .flag_we     (flag_we),
        .flag_mask   (flag_mask),
        .push        (push),
        .pop         (pop),
        .err_clr     (err_clr),
        .cond        (cond),
        .flags       (flags),
        .cond_true   (cond_true),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;
        int         depth;
        logic       err;
        logic       ct;
        string      tag;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_stack[$];
    logic [3:0] m_flags;
    logic       m_err;
    int         checks;
    int         failures;

    // Reference condition: odd codes 1..13 are base predicates, the following even code is the negation.
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v, base;
        int   k;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'd0) return 1'b1;
        if (c == 4'd15) return 1'b0;
        k = (int'(c) - 1) / 2;
        case (k)
            0:       base = z;
            1:       base = cy;
            2:       base = n;
            3:       base = v;
            4:       base = cy & ~z;
            5:       base = (n == v);
            default: base = ~z & (n == v);
        endcase
        return ((int'(c) - 1) % 2 == 1) ? ~base : base;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] mask, input logic [3:0] alu,
                         input logic ps, input logic pp, input logic clr,
                         input logic [3:0] c, input string tag);
        exp_t e;
        logic err_ev;
        @(negedge clk);
        flag_we = we; flag_mask = mask; alu_flags = alu;
        push = ps; pop = pp; err_clr = clr; cond = c;

        err_ev = (ps && pp) || (ps && m_stack.size() == DEPTH) || (pp && m_stack.size() == 0);
        if (pp && !ps && m_stack.size() > 0) begin
            m_flags = m_stack.pop_back();
        end else begin
            if (ps && !pp && m_stack.size() < DEPTH) m_stack.push_back(m_flags);
            if (we) m_flags = (m_flags & ~mask) | (alu & mask);
        end
        if (err_ev) m_err = 1'b1;
        else if (clr) m_err = 1'b0;

        e.flags = m_flags;
        e.depth = m_stack.size();
        e.err   = m_err;
        e.ct    = ref_cond(m_flags, c);
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    task automatic idle(input logic [3:0] c, input string tag);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, c, tag);
    endtask

    task automatic set_flags(input logic [3:0] f, input string tag);
        drive(1'b1, 4'hF, f, 1'b0, 1'b0, 1'b0, 4'd0, tag);
    endtask

    // Monitor: every output is registered-derived, so compare once per cycle just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, ".flags"}, int'(flags), int'(e.flags));
                check({e.tag, ".depth"}, int'(depth), e.depth);
                check({e.tag, ".full"},  int'(stack_full),  int'(e.depth == DEPTH));
                check({e.tag, ".empty"}, int'(stack_empty), int'(e.depth == 0));
                check({e.tag, ".err"},   int'(stack_err),   int'(e.err));
                check({e.tag, ".cond"},  int'(cond_true),   int'(e.ct));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_state(input string tag);
        check({tag, ".flags"}, int'(flags), 0);
        check({tag, ".depth"}, int'(depth), 0);
        check({tag, ".empty"}, int'(stack_empty), 1);
        check({tag, ".full"},  int'(stack_full), 0);
        check({tag, ".err"},   int'(stack_err), 0);
        cond = 4'd1;
        #1 check({tag, ".eq"}, int'(cond_true), 0);
        cond = 4'd2;
        #1 check({tag, ".ne"}, int'(cond_true), 1);
    endtask

    task automatic model_reset();
        m_flags = 4'h0;
        m_err   = 1'b0;
        m_stack.delete();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        alu_flags = 4'h0; flag_we = 1'b0; flag_mask = 4'h0;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0; cond = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Write Z, then read EQ/NE from the registered flags.
        set_flags(4'h4, "wr_all");
        idle(4'd1, "eq_after_wr");
        idle(4'd2, "ne_after_wr");

        // Masked update clears only C.
        set_flags(4'hF, "set_f");
        drive(1'b1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 4'd4, "mask_c");
        idle(4'd9, "hi_after_mask");

        // Push saves the pre-update value while the same-cycle write lands.
        set_flags(4'h8, "set_8");
        drive(1'b1, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0, 4'd7, "push_we");
        drive(1'b1, 4'hF, 4'h6, 1'b0, 1'b1, 1'b0, 4'd5, "pop_over_we");

        // Overflow: five pushes into a four-deep stack, then unwind.
        for (int i = 0; i < 5; i++) begin
            set_flags(4'(i + 3), "ovf_set");
            drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, "ovf_push");
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0, "unwind_pop");
        end

        // Underflow with a write still honoured, then clear; then push+pop conflict.
        drive(1'b1, 4'hF, 4'h3, 1'b0, 1'b1, 1'b0, 4'd0, "pop_empty");
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0, "err_clr");
        drive(1'b1, 4'hF, 4'h9, 1'b1, 1'b1, 1'b0, 4'd0, "push_pop");
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 4'd0, "clr_vs_set");
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0, "err_clr2");

        // Full condition sweep.
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f), "sweep_set");
            for (int c = 0; c < 16; c++) idle(4'(c), "sweep");
        end

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 4) == 0), 4'($urandom), "rand");
        end

        // Asynchronous reset mid-operation, after the scoreboard drains.
        set_flags(4'hA, "pre_rst");
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, "pre_rst_push");
        @(negedge clk);
        flag_we = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        #1;
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_flags(4'h5, "post_rst");
        idle(4'd11, "post_rst_ge");

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
        check("scoreboard_drain", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
